// File: rtl/mac_pipe_lanes.sv
// mac_pipe_lanes: multi-lane pipelined multiply-accumulate with per-lane saturation
// and sticky overflow flags.
module mac_pipe_lanes #(
  parameter int WIDTH_A   = 8,
  parameter int WIDTH_B   = 8,
  parameter int WIDTH_ACC = 24,
  parameter int LANES     = 4,
  parameter int STAGE     = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pip_en,
  input  logic                       in_valid,
  input  logic                       sgn_mode,
  input  logic                       acc_clr,
  input  logic [LANES*WIDTH_A-1:0]   A,
  input  logic [LANES*WIDTH_B-1:0]   B,
  output logic [LANES*WIDTH_ACC-1:0] ACC,
  output logic                       out_valid,
  output logic [LANES-1:0]           OVF
);
  localparam int PW = WIDTH_A + WIDTH_B;
  localparam int W  = WIDTH_ACC;
  if (WIDTH_ACC < WIDTH_A + WIDTH_B) begin : g_bad_acc
    $error("WIDTH_ACC must be >= WIDTH_A+WIDTH_B");
  end
  if (STAGE < 1) begin : g_bad_stage
    $error("STAGE must be >= 1");
  end
  logic [LANES*WIDTH_A-1:0] a_q;
  logic [LANES*WIDTH_B-1:0] b_q;
  logic                     v_q, s_q, c_q;
  logic [LANES*PW-1:0]      prod;
  logic [LANES*PW-1:0]      p_p [STAGE];
  logic [STAGE-1:0]         v_p, s_p, c_p;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      v_q <= 1'b0;
      s_q <= 1'b0;
      c_q <= 1'b0;
      v_p <= '0;
      s_p <= '0;
      c_p <= '0;
      for (int k = 0; k < STAGE; k++) p_p[k] <= '0;
      out_valid <= 1'b0;
    end else if (pip_en) begin
      a_q <= A;
      b_q <= B;
      v_q <= in_valid;
      s_q <= sgn_mode;
      c_q <= acc_clr;
      v_p[0] <= v_q;
      s_p[0] <= s_q;
      c_p[0] <= c_q;
      p_p[0] <= prod;
      for (int k = 1; k < STAGE; k++) begin
        v_p[k] <= v_p[k-1];
        s_p[k] <= s_p[k-1];
        c_p[k] <= c_p[k-1];
        p_p[k] <= p_p[k-1];
      end
      out_valid <= v_p[STAGE-1];
    end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [PW-1:0] ax, bx, pr;
    logic [W:0]    pe, ae, sum;
    logic [W-1:0]  acc_r, sat;
    logic          ovf_r, ov, sg, cl;
    // Extending both operands to the full product width makes a plain
    // truncated multiply exact for signed and unsigned alike.
    assign ax = s_q ? {{WIDTH_B{a_q[i*WIDTH_A+WIDTH_A-1]}}, a_q[i*WIDTH_A +: WIDTH_A]}
                    : {{WIDTH_B{1'b0}}, a_q[i*WIDTH_A +: WIDTH_A]};
    assign bx = s_q ? {{WIDTH_A{b_q[i*WIDTH_B+WIDTH_B-1]}}, b_q[i*WIDTH_B +: WIDTH_B]}
                    : {{WIDTH_A{1'b0}}, b_q[i*WIDTH_B +: WIDTH_B]};
    assign prod[i*PW +: PW] = ax * bx;
    assign sg  = s_p[STAGE-1];
    assign cl  = c_p[STAGE-1];
    assign pr  = p_p[STAGE-1][i*PW +: PW];
    assign pe  = sg ? {{(W+1-PW){pr[PW-1]}}, pr} : {{(W+1-PW){1'b0}}, pr};
    assign ae  = sg ? {acc_r[W-1], acc_r} : {1'b0, acc_r};
    assign sum = ae + pe;
    assign ov  = sg ? (sum[W] ^ sum[W-1]) : sum[W];
    assign sat = !ov ? sum[W-1:0]
               : sg ? (sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
               : {W{1'b1}};
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        acc_r <= '0;
        ovf_r <= 1'b0;
      end else if (pip_en && v_p[STAGE-1]) begin
        acc_r <= cl ? pe[W-1:0] : sat;
        ovf_r <= cl ? 1'b0 : (ovf_r | ov);
      end
    assign ACC[i*W +: W] = acc_r;
    assign OVF[i] = ovf_r;
  end
endmodule

// File: tb/tb_mac_pipe_lanes.sv
// tb_mac_pipe_lanes: directed and random checks of mac_pipe_lanes against an
// arithmetic reference model, with two accumulator widths driven in parallel.
module tb_mac_pipe_lanes;
  localparam int ST = 5;
  logic clk = 0, rst_n = 0, pip_en = 0, in_valid = 0, sgn_mode = 0, acc_clr = 0;
  logic [15:0] A = 0, B = 0;
  logic [47:0] acc0;
  logic [35:0] acc1;
  logic ov0, ov1;
  logic [1:0] ovf0, ovf1;
  always #5 clk = ~clk;
  mac_pipe_lanes #(.WIDTH_A(8), .WIDTH_B(8), .WIDTH_ACC(24), .LANES(2), .STAGE(ST)) u0 (
    .clk(clk), .rst_n(rst_n), .pip_en(pip_en), .in_valid(in_valid), .sgn_mode(sgn_mode),
    .acc_clr(acc_clr), .A(A), .B(B), .ACC(acc0), .out_valid(ov0), .OVF(ovf0));
  mac_pipe_lanes #(.WIDTH_A(8), .WIDTH_B(8), .WIDTH_ACC(18), .LANES(2), .STAGE(ST)) u1 (
    .clk(clk), .rst_n(rst_n), .pip_en(pip_en), .in_valid(in_valid), .sgn_mode(sgn_mode),
    .acc_clr(acc_clr), .A(A), .B(B), .ACC(acc1), .out_valid(ov1), .OVF(ovf1));
  typedef struct packed {
    int                     due;
    logic [1:0][1:0][23:0]  acc;
    logic [1:0][1:0]        ovf;
  } ent_t;
  int n_chk = 0, n_fail = 0, en_cnt = 0;
  longint macc [2][2];
  bit movf [2][2];
  ent_t q [$];
  logic [23:0] e_acc [2][2];
  logic e_ovf [2][2];
  logic e_ov;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic void mac(int d, int l, bit sg, bit clr, logic [7:0] a, logic [7:0] b);
    int w = (d == 0) ? 24 : 18;
    longint m = (longint'(1) << w) - 1;
    longint pa = sg ? longint'($signed(a)) : longint'(a);
    longint pb = sg ? longint'($signed(b)) : longint'(b);
    longint cur = (sg && macc[d][l][w-1]) ? macc[d][l] - (longint'(1) << w) : macc[d][l];
    longint lo = sg ? -(longint'(1) << (w-1)) : 0;
    longint hi = sg ? (longint'(1) << (w-1)) - 1 : m;
    longint r = clr ? pa * pb : cur + pa * pb;
    if (clr) movf[d][l] = 0;
    if (r > hi) begin r = hi; movf[d][l] = 1; end
    else if (r < lo) begin r = lo; movf[d][l] = 1; end
    macc[d][l] = r & m;
  endfunction
  function automatic void model_reset();
    q.delete();
    for (int d = 0; d < 2; d++)
      for (int l = 0; l < 2; l++) begin
        macc[d][l] = 0; movf[d][l] = 0; e_acc[d][l] = 0; e_ovf[d][l] = 0;
      end
    e_ov = 0;
  endfunction
  task automatic check_all();
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("acc w24 lane%0d", l), {40'd0, acc0[l*24 +: 24]}, {40'd0, e_acc[0][l]});
      chk($sformatf("acc w18 lane%0d", l), {46'd0, acc1[l*18 +: 18]}, {40'd0, e_acc[1][l]});
      chk($sformatf("ovf w24 lane%0d", l), {63'd0, ovf0[l]}, {63'd0, e_ovf[0][l]});
      chk($sformatf("ovf w18 lane%0d", l), {63'd0, ovf1[l]}, {63'd0, e_ovf[1][l]});
    end
    chk("out_valid w24", {63'd0, ov0}, {63'd0, e_ov});
    chk("out_valid w18", {63'd0, ov1}, {63'd0, e_ov});
  endtask
  task automatic step(bit pe, bit iv, bit sg, bit clr,
                      logic [7:0] a0, logic [7:0] b0, logic [7:0] a1, logic [7:0] b1);
    ent_t e;
    pip_en = pe; in_valid = iv; sgn_mode = sg; acc_clr = clr;
    A = {a1, a0}; B = {b1, b0};
    @(posedge clk);
    if (rst_n && pe) begin
      en_cnt++;
      e_ov = 0;
      if (q.size() > 0 && q[0].due == en_cnt) begin
        e = q.pop_front();
        e_ov = 1;
        for (int d = 0; d < 2; d++)
          for (int l = 0; l < 2; l++) begin
            e_acc[d][l] = e.acc[d][l];
            e_ovf[d][l] = e.ovf[d][l];
          end
      end
      if (iv) begin
        for (int d = 0; d < 2; d++) begin
          mac(d, 0, sg, clr, a0, b0);
          mac(d, 1, sg, clr, a1, b1);
        end
        e.due = en_cnt + ST + 1;
        for (int d = 0; d < 2; d++)
          for (int l = 0; l < 2; l++) begin
            e.acc[d][l] = macc[d][l][23:0];
            e.ovf[d][l] = movf[d][l];
          end
        q.push_back(e);
      end
    end
    #1 check_all();
  endtask
  task automatic bubble();
    step(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask
  function automatic logic [7:0] rnd_op();
    logic [7:0] corner [4] = '{8'h80, 8'h7F, 8'hFF, 8'h00};
    return ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom);
  endfunction
  task automatic do_reset(int cycles);
    #2 rst_n = 0;
    model_reset();
    #1 check_all();
    chk("reset ov immediate", {63'd0, ov0}, 64'd0);
    repeat (cycles) step(1, 1, 1, 0, 8'h11, 8'h22, 8'h33, 8'h44);
    rst_n = 1;
  endtask
  initial begin
    int acc3 [3] = '{15, 29, 44};
    model_reset();
    step(1, 1, 0, 1, 8'h12, 8'h34, 8'h56, 8'h78);
    step(1, 1, 0, 1, 8'h12, 8'h34, 8'h56, 8'h78);
    chk("reset acc", {16'd0, acc0}, 64'd0);
    rst_n = 1;
    step(1, 1, 1, 1, 8'hFB, 8'h07, 8'hFB, 8'hF9);
    repeat (6) bubble();
    chk("signed single lane0", {40'd0, acc0[23:0]}, 64'hFFFFDD);
    chk("signed single lane1", {40'd0, acc0[47:24]}, 64'd35);
    chk("signed single valid", {63'd0, ov0}, 64'd1);
    bubble();
    chk("signed single valid drop", {63'd0, ov0}, 64'd0);
    step(1, 1, 1, 1, 8'd5, 8'd3, 8'd0, 8'd0);
    step(1, 1, 1, 0, 8'd7, 8'd2, 8'd0, 8'd0);
    step(1, 1, 1, 0, 8'd15, 8'd1, 8'd0, 8'd0);
    for (int i = 0; i < 6; i++) begin
      bubble();
      if (i >= 3) begin
        chk($sformatf("accumulate #%0d", i - 3), {40'd0, acc0[23:0]}, 64'(acc3[i-3]));
        chk("accumulate valid", {63'd0, ov0}, 64'd1);
      end
    end
    step(1, 1, 0, 1, 8'hFF, 8'hFF, 8'h00, 8'h00);
    step(1, 1, 1, 1, 8'hFF, 8'hFF, 8'h00, 8'h00);
    for (int i = 0; i < 6; i++) begin
      bubble();
      if (i == 4) chk("unsigned ff*ff", {40'd0, acc0[23:0]}, 64'd65025);
      if (i == 5) chk("signed ff*ff", {40'd0, acc0[23:0]}, 64'd1);
    end
    for (int i = 0; i < 16; i++) begin
      if (i < 9) step(1, 1, 1, i == 0, 8'd127, 8'd127, 8'd0, 8'd0);
      else if (i == 9) step(1, 1, 1, 1, 8'd1, 8'd1, 8'd0, 8'd0);
      else bubble();
      if (i == 13) begin
        chk("sat 8th acc", {46'd0, acc1[17:0]}, 64'd129032);
        chk("sat 8th ovf", {63'd0, ovf1[0]}, 64'd0);
      end
      if (i == 14) begin
        chk("sat 9th acc", {46'd0, acc1[17:0]}, 64'd131071);
        chk("sat 9th ovf", {63'd0, ovf1[0]}, 64'd1);
      end
      if (i == 15) begin
        chk("sat clr acc", {46'd0, acc1[17:0]}, 64'd1);
        chk("sat clr ovf", {63'd0, ovf1[0]}, 64'd0);
      end
    end
    for (int i = 0; i < 13; i++) begin
      if (i >= 5 && i < 8) step(0, 1, 1, 0, 8'hAA, 8'h55, 8'hAA, 8'h55);
      else step(1, 1, 1'($urandom), i == 0, rnd_op(), rnd_op(), rnd_op(), rnd_op());
    end
    repeat (8) bubble();
    repeat (4) step(1, 1, 1, 1, 8'd9, 8'd9, 8'd3, 8'd3);
    do_reset(2);
    chk("reset acc cleared", {16'd0, acc0}, 64'd0);
    repeat (10) bubble();
    chk("no stale result", {63'd0, ov0}, 64'd0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, 1'($urandom),
           $urandom_range(0, 4) == 0, rnd_op(), rnd_op(), rnd_op(), rnd_op());
    repeat (8) bubble();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
